// File: rtl/serial_readout_pkg.sv
// Shared definitions for the serial readout path.
//
// Contents:
//   state_t         - readout controller states (IDLE, FETCH, SHIFT, DONE)
//   bit_cnt_width   - width of the per-word bit counter, $clog2(DATA_W)
//   word_cnt_width  - width of the word counter, $clog2(NUM_WORDS)+1
//
// The widths are functions because they depend on the parameters of each
// controller instance. The controller turns them into its BIT_CNT_W and
// WORD_CNT_W localparams.
package serial_readout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of bits needed to count 0 .. data_w-1.
    function automatic int bit_cnt_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    // The extra bit keeps NUM_WORDS=1 at a legal width of 1.
    function automatic int word_cnt_width(input int num_words);
        return $clog2(num_words) + 1;
    endfunction

endpackage

// File: rtl/serial_readout_ctrl_piso.sv
// readout_piso: parallel-load / serial-shift register for the readout path.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (clears the register)
//   load   in   load d into the register (has priority over shift)
//   shift  in   move the register by one bit towards the output end
//   d      in   parallel word, DATA_W bits
//   serial out  current output bit: bit DATA_W-1 when MSB_FIRST=1, else bit 0
//
// The register contains no control logic. The controller decides when to load
// and when to shift.
module readout_piso #(
    parameter int DATA_W    = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              serial
);

    logic [DATA_W-1:0] sreg;

    // When MSB_FIRST=1 the word moves left and the MSB leaves first.
    // When MSB_FIRST=0 the word moves right and the LSB leaves first.
    // The output end is always the bit that serial presents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= d;
        end else if (shift) begin
            if (MSB_FIRST != 0) begin
                sreg <= {sreg[DATA_W-2:0], 1'b0};
            end else begin
                sreg <= {1'b0, sreg[DATA_W-1:1]};
            end
        end
    end

    assign serial = (MSB_FIRST != 0) ? sreg[DATA_W-1] : sreg[0];

endmodule

// File: rtl/serial_readout_ctrl.sv
// serial_readout_ctrl: streams NUM_WORDS words from the result SRAM out as
// one gapless serial frame. A rising edge of read_external starts the frame.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   read_external  in   request: a rising edge starts a frame, a low level aborts
//   base_addr      in   address of the first word, captured at the start edge
//   mem_rd_en      out  SRAM read strobe
//   mem_addr       out  SRAM read address (0 when no read is issued)
//   mem_rd_data    in   SRAM data, valid MEM_LAT cycles after the strobe edge
//   serial_out     out  frame bit (forced to 0 outside SHIFT)
//   serial_valid   out  serial_out carries a frame bit
//   frame_start    out  high together with the first bit of the frame
//   busy           out  frame in progress (FETCH or SHIFT)
//   done           out  frame finished, waiting for read_external to drop
module serial_readout_ctrl
    import serial_readout_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_WORDS   = 3,
    parameter int ADDR_W      = 11,
    parameter int ADDR_STRIDE = 1,
    parameter int MEM_LAT     = 1,
    parameter int MSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_external,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              frame_start,
    output logic              busy,
    output logic              done
);

    localparam int BIT_CNT_W  = bit_cnt_width(DATA_W);
    localparam int WORD_CNT_W = word_cnt_width(NUM_WORDS);

    localparam logic [BIT_CNT_W-1:0]  LAST_BIT     = BIT_CNT_W'(DATA_W - 1);
    localparam logic [BIT_CNT_W-1:0]  PREFETCH_BIT = BIT_CNT_W'(DATA_W - 1 - MEM_LAT);
    localparam logic [BIT_CNT_W-1:0]  LAT_LAST     = BIT_CNT_W'(MEM_LAT);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD    = WORD_CNT_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0]     STRIDE       = ADDR_W'(ADDR_STRIDE);

    state_t                state;
    state_t                state_next;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt_next;
    logic [WORD_CNT_W-1:0] word_cnt;
    logic [WORD_CNT_W-1:0] word_cnt_next;
    logic [ADDR_W-1:0]     word_addr;
    logic [ADDR_W-1:0]     word_addr_next;
    logic                  req_d;
    logic                  armed;
    logic                  start;
    logic                  more_words;
    logic                  piso_load;
    logic                  piso_shift;
    logic                  piso_bit;

    readout_piso #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk    (clk),
        .rst    (rst),
        .load   (piso_load),
        .shift  (piso_shift),
        .d      (mem_rd_data),
        .serial (piso_bit)
    );

    // armed is set only after read_external has been seen low since reset.
    // Without it, a request held high through reset would look like a rising
    // edge, because req_d clears to 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            word_addr <= '0;
            req_d     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            word_cnt  <= word_cnt_next;
            word_addr <= word_addr_next;
            req_d     <= read_external;
            if (!read_external) begin
                armed <= 1'b1;
            end
        end
    end

    // In FETCH, bit_cnt counts the memory latency. In SHIFT, it counts the
    // position inside the current word. word_addr holds the address of the
    // word being shifted, so the prefetch address is word_addr + STRIDE.
    // Adding in ADDR_W bits makes the address wrap modulo 2^ADDR_W.
    // The abort check comes first, so an abort at the last-bit edge goes to
    // IDLE, not DONE.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        word_cnt_next  = word_cnt;
        word_addr_next = word_addr;
        piso_load      = 1'b0;
        piso_shift     = 1'b0;
        mem_rd_en      = 1'b0;
        mem_addr       = '0;
        serial_out     = 1'b0;
        serial_valid   = 1'b0;
        frame_start    = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        start      = read_external & ~req_d & armed;
        more_words = (word_cnt < LAST_WORD);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = FETCH;
                    word_addr_next = base_addr;
                    word_cnt_next  = '0;
                    bit_cnt_next   = '0;
                end
            end

            FETCH: begin
                busy = 1'b1;
                if (bit_cnt == '0) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = word_addr;
                end
                if (!read_external) begin
                    state_next = IDLE;
                end else if (bit_cnt == LAT_LAST) begin
                    piso_load    = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end else begin
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                end
            end

            SHIFT: begin
                busy         = 1'b1;
                serial_valid = 1'b1;
                serial_out   = piso_bit;
                frame_start  = (word_cnt == '0) && (bit_cnt == '0);
                // The read is issued MEM_LAT cycles ahead of the word
                // boundary, so the next word arrives exactly at the last-bit
                // edge.
                if ((bit_cnt == PREFETCH_BIT) && more_words) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = word_addr + STRIDE;
                end
                if (!read_external) begin
                    state_next = IDLE;
                end else if (bit_cnt == LAST_BIT) begin
                    if (more_words) begin
                        piso_load      = 1'b1;
                        bit_cnt_next   = '0;
                        word_cnt_next  = word_cnt + WORD_CNT_W'(1);
                        word_addr_next = word_addr + STRIDE;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    piso_shift   = 1'b1;
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                end
            end

            DONE: begin
                done = 1'b1;
                if (!read_external) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_readout_ctrl.sv
// tb_serial_readout_ctrl: scoreboard bench for serial_readout_ctrl.
//
// The bench instantiates two configurations:
//   A: default parameters (16-bit words, 3 words, MEM_LAT=1, MSB first)
//   B: DATA_W=8, NUM_WORDS=4, MEM_LAT=3, MSB_FIRST=0
//
// Each instance has its own SRAM model. The stimulus pushes the expected
// addresses and bits into queues. Negedge monitors pop a queue entry whenever
// the DUT issues a read or presents a valid bit, and compare it.
module tb_serial_readout_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Signals for instance A (default parameters)
    logic        re_a = 1'b0;
    logic [10:0] base_a = '0;
    logic        rd_en_a;
    logic [10:0] addr_a;
    logic [15:0] rdata_a = '0;
    logic        so_a, sv_a, fs_a, busy_a, done_a;
    logic [15:0] mem_a [0:2047];

    // Signals for instance B (8-bit words, 4 words, MEM_LAT=3, LSB first)
    logic        re_b = 1'b0;
    logic [10:0] base_b = '0;
    logic        rd_en_b;
    logic [10:0] addr_b;
    logic [7:0]  rdata_b;
    logic        so_b, sv_b, fs_b, busy_b, done_b;
    logic [7:0]  mem_b [0:2047];
    logic [7:0]  pipe_b [3];

    // Scoreboard queues. Bit entries are {serial_out, frame_start}.
    logic [10:0] addrs_a [$];
    logic [1:0]  bits_a  [$];
    logic [10:0] addrs_b [$];
    logic [1:0]  bits_b  [$];

    serial_readout_ctrl dut_a (
        .clk           (clk),
        .rst           (rst),
        .read_external (re_a),
        .base_addr     (base_a),
        .mem_rd_en     (rd_en_a),
        .mem_addr      (addr_a),
        .mem_rd_data   (rdata_a),
        .serial_out    (so_a),
        .serial_valid  (sv_a),
        .frame_start   (fs_a),
        .busy          (busy_a),
        .done          (done_a)
    );

    serial_readout_ctrl #(
        .DATA_W      (8),
        .NUM_WORDS   (4),
        .ADDR_W      (11),
        .ADDR_STRIDE (1),
        .MEM_LAT     (3),
        .MSB_FIRST   (0)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .read_external (re_b),
        .base_addr     (base_b),
        .mem_rd_en     (rd_en_b),
        .mem_addr      (addr_b),
        .mem_rd_data   (rdata_b),
        .serial_out    (so_b),
        .serial_valid  (sv_b),
        .frame_start   (fs_b),
        .busy          (busy_b),
        .done          (done_b)
    );

    // SRAM A model: one cycle of read latency.
    always @(posedge clk) begin
        rdata_a <= rd_en_a ? mem_a[addr_a] : 16'h0000;
    end

    // SRAM B model: three pipeline stages give three cycles of read latency.
    always @(posedge clk) begin
        pipe_b[0] <= rd_en_b ? mem_b[addr_b] : 8'h00;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rdata_b = pipe_b[2];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Moves to 2 time units after the n-th next rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic a_req, input logic [10:0] a_base,
                                 input logic b_req, input logic [10:0] b_base);
        re_a   = a_req;
        base_a = a_base;
        re_b   = b_req;
        base_b = b_base;
    endtask

    // Monitor A: address and bit scoreboard, plus a check that serial_out is
    // 0 whenever no valid bit is presented.
    logic [10:0] exp_addr_a;
    logic [1:0]  exp_bit_a;
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en_a) begin
                if (addrs_a.size() == 0) begin
                    checkOutput("a_unexpected_read", {1'b1, addr_a}, 12'h000);
                end else begin
                    exp_addr_a = addrs_a.pop_front();
                    checkOutput("a_mem_addr", addr_a, exp_addr_a);
                end
            end
            if (sv_a) begin
                if (bits_a.size() == 0) begin
                    checkOutput("a_unexpected_bit", 1'b1, 1'b0);
                end else begin
                    exp_bit_a = bits_a.pop_front();
                    checkOutput("a_bit_fs", {so_a, fs_a}, exp_bit_a);
                end
            end else begin
                checkOutput("a_idle_out", {so_a, fs_a}, 2'b00);
            end
        end
    end

    // Monitor B: the same scoreboard, plus a check on the position of the
    // prefetch inside the word.
    logic [10:0] exp_addr_b;
    logic [1:0]  exp_bit_b;
    int          bit_idx_b = 0;
    int          cur_idx_b;
    always @(negedge clk) begin
        if (!rst) begin
            cur_idx_b = fs_b ? 0 : bit_idx_b;
            if (rd_en_b) begin
                if (sv_b) begin
                    checkOutput("b_prefetch_pos", cur_idx_b % 8, 4);
                end
                if (addrs_b.size() == 0) begin
                    checkOutput("b_unexpected_read", {1'b1, addr_b}, 12'h000);
                end else begin
                    exp_addr_b = addrs_b.pop_front();
                    checkOutput("b_mem_addr", addr_b, exp_addr_b);
                end
            end
            if (sv_b) begin
                if (bits_b.size() == 0) begin
                    checkOutput("b_unexpected_bit", 1'b1, 1'b0);
                end else begin
                    exp_bit_b = bits_b.pop_front();
                    checkOutput("b_bit_fs", {so_b, fs_b}, exp_bit_b);
                end
                bit_idx_b = cur_idx_b + 1;
            end else begin
                checkOutput("b_idle_out", {so_b, fs_b}, 2'b00);
            end
        end
    end

    // Expected traffic for A: the first nreads addresses, and the first nbits
    // bits taken MSB first from the hand-picked words.
    task automatic push_frame_a(input logic [10:0] base, input logic [15:0] w0,
                                input logic [15:0] w1, input logic [15:0] w2,
                                input int nbits, input int nreads);
        logic [15:0] w [3];
        logic [10:0] a;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        for (int k = 0; k < nreads; k++) begin
            a = base + 11'(k);
            addrs_a.push_back(a);
        end
        for (int i = 0; i < nbits; i++) begin
            bits_a.push_back({w[i / 16][15 - (i % 16)], (i == 0) ? 1'b1 : 1'b0});
        end
    endtask

    // Complete frame on A: checks the two-cycle first-bit latency, that the
    // 48 bits are gapless, and that DONE follows. read_external stays high.
    task automatic run_full_a(input logic [10:0] base, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] w2);
        int gaps;
        push_frame_a(base, w0, w1, w2, 48, 3);
        applyStimulus(1'b1, base, 1'b0, 11'h000);
        tick(1);
        checkOutput("a_fetch_state", {busy_a, rd_en_a, sv_a, done_a}, 4'b1100);
        tick(1);
        checkOutput("a_latency_no_bit", sv_a, 1'b0);
        tick(1);
        checkOutput("a_first_bit_at_2", {sv_a, fs_a}, 2'b11);
        gaps = 0;
        repeat (47) begin
            tick(1);
            if (sv_a !== 1'b1 || fs_a !== 1'b0) gaps++;
        end
        checkOutput("a_gapless_48", gaps, 0);
        tick(1);
        checkOutput("a_done_after_47", {done_a, busy_a, sv_a, rd_en_a}, 4'b1000);
        checkOutput("a_bits_drained", bits_a.size(), 0);
        checkOutput("a_addrs_drained", addrs_a.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        int stuck;
        for (int i = 0; i < 2048; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 8'h00;
        end
        mem_a[5]     = 16'h1771;
        mem_a[6]     = 16'h17A4;
        mem_a[7]     = 16'h0019;
        mem_a[2047]  = 16'hBEEF;
        mem_a[0]     = 16'h0123;
        mem_a[1]     = 16'hC3A5;
        mem_b[16]    = 8'hA5;
        mem_b[17]    = 8'h3C;
        mem_b[18]    = 8'hFF;
        mem_b[19]    = 8'h01;

        // Reset state
        #1 rst = 1'b1;
        #1;
        checkOutput("reset_outputs_a", {rd_en_a, addr_a, so_a, sv_a, fs_a, busy_a, done_a}, '0);
        checkOutput("reset_outputs_b", {rd_en_b, addr_b, so_b, sv_b, fs_b, busy_b, done_b}, '0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Basic frame, then read_external held high in DONE for 50 cycles
        run_full_a(11'd5, 16'h1771, 16'h17A4, 16'h0019);
        stuck = 0;
        repeat (50) begin
            tick(1);
            if (done_a !== 1'b1 || rd_en_a !== 1'b0 || sv_a !== 1'b0 || busy_a !== 1'b0) stuck++;
        end
        checkOutput("a_hold_in_done_50", stuck, 0);
        applyStimulus(1'b0, 11'd5, 1'b0, 11'h000);
        tick(1);
        checkOutput("a_idle_after_drop", {done_a, busy_a}, 2'b00);

        // Address wrap: 0x7FF, 0x000, 0x001
        tick(1);
        run_full_a(11'h7FF, 16'hBEEF, 16'h0123, 16'hC3A5);
        applyStimulus(1'b0, 11'h7FF, 1'b0, 11'h000);
        tick(1);

        // Abort after bit 20
        push_frame_a(11'd5, 16'h1771, 16'h17A4, 16'h0019, 21, 2);
        applyStimulus(1'b1, 11'd5, 1'b0, 11'h000);
        tick(3);
        tick(20);
        applyStimulus(1'b0, 11'd5, 1'b0, 11'h000);
        tick(1);
        checkOutput("a_abort_next_cycle", {sv_a, busy_a, rd_en_a, done_a}, 4'b0000);
        stuck = 0;
        repeat (20) begin
            tick(1);
            if (rd_en_a !== 1'b0 || sv_a !== 1'b0 || busy_a !== 1'b0) stuck++;
        end
        checkOutput("a_abort_quiet", stuck, 0);
        checkOutput("a_abort_bits_drained", bits_a.size(), 0);
        checkOutput("a_abort_addrs_drained", addrs_a.size(), 0);
        run_full_a(11'd5, 16'h1771, 16'h17A4, 16'h0019);
        applyStimulus(1'b0, 11'd5, 1'b0, 11'h000);
        tick(1);

        // Async reset at bit 30, then read_external held high
        push_frame_a(11'd5, 16'h1771, 16'h17A4, 16'h0019, 30, 2);
        applyStimulus(1'b1, 11'd5, 1'b0, 11'h000);
        tick(3);
        tick(30);
        rst = 1'b1;
        #1;
        checkOutput("a_async_reset_clear", {rd_en_a, addr_a, so_a, sv_a, fs_a, busy_a, done_a}, '0);
        tick(1);
        rst = 1'b0;
        stuck = 0;
        repeat (10) begin
            tick(1);
            if (busy_a !== 1'b0 || rd_en_a !== 1'b0 || sv_a !== 1'b0) stuck++;
        end
        checkOutput("a_no_start_held_high", stuck, 0);
        checkOutput("a_reset_bits_drained", bits_a.size(), 0);
        checkOutput("a_reset_addrs_drained", addrs_a.size(), 0);
        applyStimulus(1'b0, 11'd5, 1'b0, 11'h000);
        tick(2);
        run_full_a(11'd5, 16'h1771, 16'h17A4, 16'h0019);
        applyStimulus(1'b0, 11'd5, 1'b0, 11'h000);
        tick(1);

        // Instance B: 4 x 8-bit words, LSB first, MEM_LAT=3
        begin : frame_b
            logic [7:0] wb [4];
            int gaps;
            wb[0] = 8'hA5;
            wb[1] = 8'h3C;
            wb[2] = 8'hFF;
            wb[3] = 8'h01;
            for (int k = 0; k < 4; k++) addrs_b.push_back(11'(16 + k));
            for (int i = 0; i < 32; i++) begin
                bits_b.push_back({wb[i / 8][i % 8], (i == 0) ? 1'b1 : 1'b0});
            end
            applyStimulus(1'b0, 11'd5, 1'b1, 11'd16);
            tick(1);
            checkOutput("b_fetch_state", {busy_b, rd_en_b, sv_b}, 3'b110);
            tick(3);
            checkOutput("b_latency_no_bit", sv_b, 1'b0);
            tick(1);
            checkOutput("b_first_bit", {sv_b, fs_b}, 2'b11);
            gaps = 0;
            repeat (31) begin
                tick(1);
                if (sv_b !== 1'b1) gaps++;
            end
            checkOutput("b_gapless_32", gaps, 0);
            tick(1);
            checkOutput("b_done", {done_b, busy_b, sv_b}, 3'b100);
            checkOutput("b_bits_drained", bits_b.size(), 0);
            checkOutput("b_addrs_drained", addrs_b.size(), 0);
            applyStimulus(1'b0, 11'd5, 1'b0, 11'd16);
            tick(2);
            checkOutput("b_idle_after_drop", {done_b, busy_b}, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
